fpga_io_port: RTL and testbench

- Board-side I/O stage wrapped around the 16-bit multicycle processor (`integration3`).
- Input path: synchronizes and debounces the 16 board switches and presents them on the processor's `FPGAIn` bus.
- Output path: latches the processor's `FPGAOut` value when the processor issues an output write, then shows it in hex on a 4-digit multiplexed seven-segment display.

---
 rtl/fpga_io_port_if.sv | 21 ++
 rtl/fpga_io_port.sv | 110 +++++++++++
 tb/tb_fpga_io_port.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/fpga_io_port_if.sv
// Processor-side bus of the board I/O stage: output strobe/data in, debounced switches out.
interface fpga_io_port_if;
   logic        OutWrite;
   logic [15:0] OutData;
   logic [15:0] FPGAIn;
   logic        InChanged;

   modport master (
      output OutWrite,
      output OutData,
      input  FPGAIn,
      input  InChanged
   );

   modport slave (
      input  OutWrite,
      input  OutData,
      output FPGAIn,
      output InChanged
   );
endinterface

// File: rtl/fpga_io_port.sv
// Board I/O stage: synchronised, debounced switch input and a latched output word shown
// in hex on a 4-digit multiplexed seven-segment display.
module fpga_io_port #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned SCAN_DIV        = 4
) (
   input  logic                 CLK,
   input  logic                 reset,
   input  logic [15:0]          Switches,
   fpga_io_port_if.slave        cpu,
   output logic [15:0]          OutLatched,
   output logic [3:0]           An,
   output logic [6:0]           Seg
);

   localparam logic [15:0] CntMax = 16'(DEBOUNCE_CYCLES - 1);
   localparam logic [15:0] PreMax = 16'(SCAN_DIV - 1);

   logic [15:0] s1_q, s2_q;
   logic [15:0] cand_q, cand_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] in_q, in_d;
   logic        chg_q, chg_d;
   logic [15:0] out_q, out_d;
   logic [15:0] pre_q, pre_d;
   logic [1:0]  dig_q, dig_d;
   logic [3:0]  nibble;

   always_comb begin
      cand_d = cand_q;
      cnt_d  = cnt_q;
      in_d   = in_q;
      chg_d  = 1'b0;
      // Any disagreement with the candidate restarts the stability count.
      if (s2_q != cand_q) begin
         cand_d = s2_q;
         cnt_d  = '0;
      end else if (cnt_q == CntMax && cand_q != in_q) begin
         in_d  = cand_q;
         chg_d = 1'b1;
      end else if (cnt_q != CntMax) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_comb begin
      out_d = cpu.OutWrite ? cpu.OutData : out_q;
      pre_d = pre_q + 16'd1;
      dig_d = dig_q;
      if (pre_q == PreMax) begin
         pre_d = '0;
         dig_d = dig_q + 2'd1;
      end
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         s1_q   <= '0;
         s2_q   <= '0;
         cand_q <= '0;
         cnt_q  <= '0;
         in_q   <= '0;
         chg_q  <= 1'b0;
         out_q  <= '0;
         pre_q  <= '0;
         dig_q  <= '0;
      end else begin
         s1_q   <= Switches;
         s2_q   <= s1_q;
         cand_q <= cand_d;
         cnt_q  <= cnt_d;
         in_q   <= in_d;
         chg_q  <= chg_d;
         out_q  <= out_d;
         pre_q  <= pre_d;
         dig_q  <= dig_d;
      end
   end

   assign cpu.FPGAIn    = in_q;
   assign cpu.InChanged = chg_q;
   assign OutLatched    = out_q;
   assign An            = ~(4'b0001 << dig_q);
   assign nibble        = out_q[{dig_q, 2'b00} +: 4];

   // Active-low {g,f,e,d,c,b,a}; follows out_q directly so a write shows in the same cycle.
   always_comb begin
      Seg = 7'b1111111;
      case (nibble)
         4'h0: Seg = 7'b1000000;
         4'h1: Seg = 7'b1111001;
         4'h2: Seg = 7'b0100100;
         4'h3: Seg = 7'b0110000;
         4'h4: Seg = 7'b0011001;
         4'h5: Seg = 7'b0010010;
         4'h6: Seg = 7'b0000010;
         4'h7: Seg = 7'b1111000;
         4'h8: Seg = 7'b0000000;
         4'h9: Seg = 7'b0010000;
         4'hA: Seg = 7'b0001000;
         4'hB: Seg = 7'b0000011;
         4'hC: Seg = 7'b1000110;
         4'hD: Seg = 7'b0100001;
         4'hE: Seg = 7'b0000110;
         4'hF: Seg = 7'b0001110;
         default: Seg = 7'b1111111;
      endcase
   end

endmodule

// File: tb/tb_fpga_io_port.sv
// Self-checking bench for fpga_io_port: directed scenarios plus randomized traffic, all
// compared every cycle against a behavioural model of the switch/latch/scan rules.
module tb_fpga_io_port;
   localparam int unsigned DB = 4;
   localparam int unsigned SD = 4;

   logic        CLK = 1'b0;
   logic        reset;
   logic [15:0] Switches;
   logic [15:0] OutLatched;
   logic [3:0]  An;
   logic [6:0]  Seg;

   fpga_io_port_if bus ();

   fpga_io_port #(
      .DEBOUNCE_CYCLES (DB),
      .SCAN_DIV        (SD)
   ) dut (
      .CLK        (CLK),
      .reset      (reset),
      .Switches   (Switches),
      .cpu        (bus),
      .OutLatched (OutLatched),
      .An         (An),
      .Seg        (Seg)
   );

   always #5 CLK = ~CLK;

   int n_vec = 0;
   int n_bad = 0;

   // Model state: switch samples since reset, current stable run of the synchronised value.
   logic [15:0] hist[$];
   logic [15:0] m_in, m_run_v, m_out;
   int          m_run, m_edges;
   logic        m_chg;

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
         4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;  default: return 7'b0001110;
      endcase
   endfunction

   task automatic model_reset();
      hist.delete();
      m_in    = '0;
      m_run_v = '0;
      m_run   = 1;
      m_out   = '0;
      m_chg   = 1'b0;
      m_edges = 0;
   endtask

   task automatic model_edge();
      logic [15:0] s2;
      // The synchroniser presents at this edge what the switches were two edges ago.
      s2 = (hist.size() >= 2) ? hist[hist.size() - 2] : 16'h0000;
      hist.push_back(Switches);
      if (hist.size() > 2) void'(hist.pop_front());
      if (s2 == m_run_v) m_run++;
      else begin
         m_run_v = s2;
         m_run   = 1;
      end
      m_chg = 1'b0;
      if (m_run >= int'(DB) + 1 && m_run_v != m_in) begin
         m_in  = m_run_v;
         m_chg = 1'b1;
      end
      if (bus.OutWrite) m_out = bus.OutData;
      m_edges++;
   endtask

   task automatic check_all();
      int          dig;
      logic [3:0]  nib;
      dig = (m_edges / int'(SD)) % 4;
      nib = 4'((m_out >> (4 * dig)) & 16'h000F);
      check_eq("fpgain", bus.FPGAIn, m_in);
      check_eq("inchanged", {15'd0, bus.InChanged}, {15'd0, m_chg});
      check_eq("outlatched", OutLatched, m_out);
      check_eq("an", {12'd0, An}, {12'd0, ~(4'b0001 << dig)});
      check_eq("seg", {9'd0, Seg}, {9'd0, hex7(nib)});
   endtask

   // One clock with the model advanced; inputs must already be set.
   task automatic cycle();
      @(posedge CLK);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic cycle_in_reset();
      @(posedge CLK);
      #1;
      check_all();
   endtask

   initial begin
      int pulses;
      int found;
      reset        = 1'b0;
      Switches     = 16'hFFFF;
      bus.OutWrite = 1'b1;
      bus.OutData  = 16'hABCD;
      model_reset();
      #2;
      check_all();
      for (int i = 0; i < 4; i++) cycle_in_reset();

      // Release between edges; first counted edge is the next one.
      Switches     = 16'h0000;
      bus.OutWrite = 1'b0;
      reset        = 1'b1;
      for (int i = 0; i < 6; i++) cycle();

      // Bounce on bit 0 every 2 cycles must never be accepted.
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         Switches = ((i / 2) % 2 == 0) ? 16'h0001 : 16'h0000;
         cycle();
         if (bus.InChanged) pulses++;
      end
      Switches = 16'h0000;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (bus.InChanged) pulses++;
      end
      check_eq("bounce_pulses", 16'(pulses), 16'd0);
      check_eq("bounce_fpgain", bus.FPGAIn, 16'h0000);

      // Clean change: visible on the 7th edge counting the first sampling edge.
      Switches = 16'h00A5;
      for (int i = 0; i < 6; i++) cycle();
      check_eq("clean_early", bus.FPGAIn, 16'h0000);
      cycle();
      check_eq("clean_value", bus.FPGAIn, 16'h00A5);
      check_eq("clean_pulse", {15'd0, bus.InChanged}, 16'd1);
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         cycle();
         if (bus.InChanged) pulses++;
      end
      check_eq("clean_no_more_pulses", 16'(pulses), 16'd0);

      // Output latch and one full scan refresh.
      bus.OutWrite = 1'b1;
      bus.OutData  = 16'h1234;
      cycle();
      bus.OutWrite = 1'b0;
      check_eq("latch_1234", OutLatched, 16'h1234);
      for (int i = 0; i < 20; i++) cycle();

      // Back-to-back writes: last one wins.
      bus.OutWrite = 1'b1;
      bus.OutData  = 16'hBEEF;
      cycle();
      bus.OutData  = 16'hC0DE;
      cycle();
      bus.OutWrite = 1'b0;
      check_eq("latch_c0de", OutLatched, 16'hC0DE);
      found = 0;
      for (int i = 0; i < 4 * int'(SD) + 1 && found == 0; i++) begin
         if (An == 4'b1110) begin
            found = 1;
            check_eq("digit0_E", {9'd0, Seg}, {9'd0, 7'b0000110});
         end else begin
            cycle();
         end
      end
      check_eq("digit0_seen", 16'(found), 16'd1);

      // Reset in the middle of a debounce while digit 2 is lit.
      for (int i = 0; i < 4 * int'(SD) && (m_edges % (4 * int'(SD))) != 2 * int'(SD); i++)
         cycle();
      Switches = 16'hFFFF;
      cycle();
      cycle();
      check_eq("pre_reset_digit2", {12'd0, An}, 16'h000B);
      reset = 1'b0;
      model_reset();
      #1;
      check_eq("reset_an", {12'd0, An}, 16'h000E);
      check_eq("reset_fpgain", bus.FPGAIn, 16'h0000);
      check_all();
      cycle_in_reset();
      cycle_in_reset();
      reset = 1'b1;
      for (int i = 0; i < 6; i++) cycle();
      check_eq("post_reset_early", bus.FPGAIn, 16'h0000);
      cycle();
      check_eq("post_reset_ffff", bus.FPGAIn, 16'hFFFF);

      // Randomized traffic: held switch values of random length, random writes.
      for (int seg = 0; seg < 80; seg++) begin
         int hold;
         hold = int'($urandom_range(1, 8));
         if ($urandom_range(0, 1) == 0) Switches = 16'($urandom);
         else Switches = Switches ^ (16'h0001 << $urandom_range(0, 15));
         for (int k = 0; k < hold; k++) begin
            bus.OutWrite = ($urandom_range(0, 2) == 0);
            bus.OutData  = 16'($urandom);
            cycle();
         end
      end
      bus.OutWrite = 1'b0;
      for (int i = 0; i < 10; i++) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
